// File: rtl/spi_slave_gen.sv
// -----------------------------------------------------------------------------
// spi_slave_gen
// Command/address/data SPI slave front end for a small RAM.
//
// Each frame is FRAME_W = ADDR_SIZE+2 bits, MSB first: {cmd[1:0], payload}.
// The slave samples MOSI once per clk while SS_n is low. The first command
// bit selects the path in CHK_CMD:
//   0  -> WRITE      (address or data frame for a write)
//   1  -> READ_ADD   (read address; sets addr_rcvd)
//   1  -> READ_DATA  (when addr_rcvd is already set; returns one RAM byte)
//
// Handshake:
//   rx_valid is a one-cycle strobe; rx_data is valid in that cycle and
//   holds until the next frame completes. tx_valid/tx_data are only
//   accepted while a READ_DATA frame is waiting for its byte. tx_valid at
//   any other time is ignored. There is no back-pressure on either side.
//
// Optional feature (macro SPI_BURST_EN): after each returned byte, if SS_n
// is still low, rx_valid re-pulses with {2'b11, last payload} and the slave
// waits for the next byte. addr_rcvd then clears only when SS_n rises.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   SS_n       in   slave select, active low
//   MOSI       in   serial data in
//   MISO       out  serial read data out (0 when idle)
//   rx_data    out  received frame {cmd, payload}
//   rx_valid   out  one-cycle strobe for rx_data
//   tx_data    in   read byte from RAM
//   tx_valid   in   qualifies tx_data
//   state_dbg  out  current FSM state encoding
//   addr_rcvd  out  read address has been received
// -----------------------------------------------------------------------------
module spi_slave_gen #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic [2:0]           state_dbg,
  output logic                 addr_rcvd
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int TX_CW   = $clog2(ADDR_SIZE + 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(FRAME_W - 1);
  localparam logic [TX_CW-1:0] TX_LAST  = TX_CW'(ADDR_SIZE);

  if (2**ADDR_SIZE < MEM_DEPTH) begin : g_depth_check
    $error("spi_slave_gen: MEM_DEPTH does not fit in 2**ADDR_SIZE");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CHK_CMD   = 3'b001,
    READ_ADD  = 3'b010,
    READ_DATA = 3'b011,
    WRITE     = 3'b100
  } state_t;

  state_t               state, next_state;
  logic [BC_W-1:0]      bit_cnt;
  logic [FRAME_W-1:0]   shift_reg;
  logic                 frame_done;  // frame received; stop shifting until SS_n rises
  logic                 tx_wait;     // READ_DATA waiting for the RAM byte
  logic                 tx_active;   // MISO shift-out in progress
  logic [TX_CW-1:0]     tx_cnt;
  logic [ADDR_SIZE-1:0] tx_reg;
  logic                 in_shift;
  logic                 last_bit;

  assign state_dbg = state;

  assign in_shift = !SS_n && !frame_done &&
                    (state == WRITE || state == READ_ADD || state == READ_DATA);
  assign last_bit = in_shift && (bit_cnt == BIT_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        // The command bit is only inspected here; it is shifted in as the
        // first frame bit on entry to the selected state.
        if (!MOSI)          next_state = WRITE;
        else if (addr_rcvd) next_state = READ_DATA;
        else                next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: next_state = state;
      default:   next_state = IDLE;
    endcase
    if (SS_n) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      MISO       <= 1'b0;
      addr_rcvd  <= 1'b0;
      frame_done <= 1'b0;
      tx_wait    <= 1'b0;
      tx_active  <= 1'b0;
      tx_cnt     <= '0;
      tx_reg     <= '0;
    end else begin
      state    <= next_state;
      rx_valid <= 1'b0;
      if (SS_n) begin
        // Deselect drops any partial frame, including one whose last bit
        // is sampled on this very edge.
        bit_cnt    <= '0;
        shift_reg  <= '0;
        frame_done <= 1'b0;
        tx_wait    <= 1'b0;
        tx_active  <= 1'b0;
        tx_cnt     <= '0;
        MISO       <= 1'b0;
`ifdef SPI_BURST_EN
        if (state == READ_DATA && frame_done) addr_rcvd <= 1'b0;
`endif
      end else begin
        if (in_shift) begin
          shift_reg <= {shift_reg[FRAME_W-2:0], MOSI};
          if (last_bit) begin
            bit_cnt    <= '0;
            frame_done <= 1'b1;
            rx_valid   <= 1'b1;
            rx_data    <= {shift_reg[FRAME_W-2:0], MOSI};
            if (state == READ_ADD)  addr_rcvd <= 1'b1;
            if (state == READ_DATA) tx_wait   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        if (tx_wait && tx_valid) begin
          // First output bit appears the cycle after capture.
          tx_wait   <= 1'b0;
          tx_active <= 1'b1;
          MISO      <= tx_data[ADDR_SIZE-1];
          tx_reg    <= {tx_data[ADDR_SIZE-2:0], 1'b0};
          tx_cnt    <= TX_CW'(1);
        end else if (tx_active) begin
          if (tx_cnt == TX_LAST) begin
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            MISO      <= 1'b0;
`ifdef SPI_BURST_EN
            rx_valid  <= 1'b1;
            rx_data   <= {2'b11, rx_data[ADDR_SIZE-1:0]};
            tx_wait   <= 1'b1;
`else
            addr_rcvd <= 1'b0;
`endif
          end else begin
            MISO   <= tx_reg[ADDR_SIZE-1];
            tx_reg <= {tx_reg[ADDR_SIZE-2:0], 1'b0};
            tx_cnt <= tx_cnt + TX_CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_gen
// Directed bench for spi_slave_gen (ADDR_SIZE=8). Frames are driven with the
// command bit held through IDLE/CHK_CMD, then one bit per clock. Expected
// rx_data values are queued when a frame is issued and popped by a monitor
// on every rx_valid cycle. Build with +define+SPI_BURST_EN to check burst.
// -----------------------------------------------------------------------------
module tb_spi_slave_gen;

  localparam int ADDR_SIZE = 8;
  localparam int FRAME_W   = ADDR_SIZE + 2;

  localparam logic [2:0] S_IDLE      = 3'b000;
  localparam logic [2:0] S_READ_ADD  = 3'b010;
  localparam logic [2:0] S_READ_DATA = 3'b011;
  localparam logic [2:0] S_WRITE     = 3'b100;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ss_n = 1'b1;
  logic                 mosi = 1'b0;
  logic                 miso;
  logic [FRAME_W-1:0]   rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data = '0;
  logic                 tx_valid = 1'b0;
  logic [2:0]           state_dbg;
  logic                 addr_rcvd;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rx_cyc = 0;
  logic [FRAME_W-1:0] exp_q[$];
  logic [FRAME_W-1:0] mon_exp;

  spi_slave_gen #(.ADDR_SIZE(ADDR_SIZE), .MEM_DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (ss_n),
    .MOSI      (mosi),
    .MISO      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .state_dbg (state_dbg),
    .addr_rcvd (addr_rcvd)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor: every rx_valid cycle consumes one expectation
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      rx_cyc = cyc;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rx_frame: got %h, none expected", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp) begin
          n_err++;
          $display("FAIL rx_frame: got %h expected %h", rx_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives nbits of frame f; returns the cycle count when SS_n fell.
  task automatic send_frame(input logic [FRAME_W-1:0] f, input int nbits, output int start);
    ss_n  = 1'b0;
    mosi  = f[FRAME_W-1];
    start = cyc;
    step(2);
    for (int i = FRAME_W - 1; i > FRAME_W - 1 - nbits; i--) begin
      mosi = f[i];
      step(1);
    end
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    step(1);
  endtask

  // Samples 8 MISO bits starting right after the capture edge.
  task automatic read_byte(input bit raise_last, output logic [ADDR_SIZE-1:0] b);
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      b[i] = miso;
      if (i == 0 && raise_last) ss_n = 1'b1;
      step(1);
    end
  endtask

  task automatic give_byte(input logic [ADDR_SIZE-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    tx_data  = '0;
  endtask

  initial begin
    int start;
    logic [ADDR_SIZE-1:0] b;

    // reset state
    step(2);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_miso", miso, 0);
    check("rst_addr_rcvd", addr_rcvd, 0);
    rst_n = 1'b1;
    step(2);

    // write frame 00_1010_0101
    exp_q.push_back(10'h0A5);
    send_frame(10'h0A5, FRAME_W, start);
    check("write_state", state_dbg, S_WRITE);
    step(1);
    check("write_latency", rx_cyc - start - 1, 11);
    tx_data = 8'hFF; tx_valid = 1'b1;
    step(3);
    check("write_ignore_tx", miso, 0);
    check("write_hold_state", state_dbg, S_WRITE);
    tx_valid = 1'b0; tx_data = '0;
    end_frame();
    check("write_end_idle", state_dbg, S_IDLE);
    check("rx_data_hold", rx_data, 10'h0A5);
    step(1);

    // read address 10_0011_0000
    exp_q.push_back(10'h230);
    send_frame(10'h230, FRAME_W, start);
    check("rdadd_state", state_dbg, S_READ_ADD);
    check("rdadd_addr_rcvd", addr_rcvd, 1);
    end_frame();
    check("addr_rcvd_retained", addr_rcvd, 1);
    step(1);

    // read data 11_0000_0000, RAM returns C3
    exp_q.push_back(10'h300);
    send_frame(10'h300, FRAME_W, start);
    check("rddata_state", state_dbg, S_READ_DATA);
    step(2);
    check("rddata_wait_miso", miso, 0);
`ifdef SPI_BURST_EN
    exp_q.push_back(10'h300);
`endif
    give_byte(8'hC3);
    read_byte(1'b0, b);
    check("miso_byte_c3", b, 8'hC3);
    check("miso_after_byte", miso, 0);
`ifdef SPI_BURST_EN
    check("burst_addr_kept", addr_rcvd, 1);
    give_byte(8'h3C);
    read_byte(1'b1, b);
    check("miso_byte_3c", b, 8'h3C);
    check("burst_end_idle", state_dbg, S_IDLE);
    check("burst_addr_clr", addr_rcvd, 0);
`else
    check("rddata_addr_clr", addr_rcvd, 0);
    check("rddata_hold_state", state_dbg, S_READ_DATA);
    tx_data = 8'hFF; tx_valid = 1'b1;
    step(3);
    check("rddata_ignore_tx", miso, 0);
    tx_valid = 1'b0; tx_data = '0;
    end_frame();
`endif
    step(1);

    // 11_xxxx with addr_rcvd=0 goes to READ_ADD
    exp_q.push_back(10'h355);
    send_frame(10'h355, FRAME_W, start);
    check("cmd11_no_addr_state", state_dbg, S_READ_ADD);
    end_frame();
    step(1);

    // abort after 5 bits, then a clean frame
    send_frame(10'h0A5, 5, start);
    ss_n = 1'b1;
    step(1);
    check("abort5_idle", state_dbg, S_IDLE);
    check("abort5_addr_kept", addr_rcvd, 1);
    step(1);
    exp_q.push_back(10'h0F0);
    send_frame(10'h0F0, FRAME_W, start);
    check("after_abort_state", state_dbg, S_WRITE);
    end_frame();
    step(1);

    // SS_n rises on the edge that samples the last bit
    send_frame(10'h0C3, FRAME_W - 1, start);
    mosi = 1'b1;
    ss_n = 1'b1;
    step(1);
    check("late_abort_idle", state_dbg, S_IDLE);
    step(2);

    // async reset during READ_DATA shift-out
    exp_q.push_back(10'h300);
    send_frame(10'h300, FRAME_W, start);
    check("rst_mid_state", state_dbg, S_READ_DATA);
    give_byte(8'hC3);
    check("rst_mid_miso_pre", miso, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_miso", miso, 0);
    check("async_rst_rx_valid", rx_valid, 0);
    check("async_rst_addr", addr_rcvd, 0);
    check("async_rst_state", state_dbg, S_IDLE);
    ss_n = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);
    exp_q.push_back(10'h155);
    send_frame(10'h155, FRAME_W, start);
    check("post_rst_state", state_dbg, S_WRITE);
    end_frame();
    step(3);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_gen.md
SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, giving the payload width per frame; frame length FRAME_W = ADDR_SIZE+2 (2 command bits plus payload).
REQ-002 SHALL have parameter MEM_DEPTH, default 256, checked at elaboration: 2**ADDR_SIZE >= MEM_DEPTH, elaboration error otherwise.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port SS_n, input, 1 bit: slave select, active low; frame boundary.
REQ-006 Port MOSI, input, 1 bit: serial data in, MSB first, sampled each clk while SS_n is low.
REQ-007 Port MISO, output, 1 bit: serial read data out, MSB first.
REQ-008 Port rx_data, output, FRAME_W bits: the received frame {cmd[1:0], payload}.
REQ-009 Port rx_valid, output, 1 bit: single-cycle strobe qualifying rx_data.
REQ-010 Port tx_data, input, ADDR_SIZE bits: read data returned by the RAM.
REQ-011 Port tx_valid, input, 1 bit: qualifies tx_data.

Function
REQ-012 FSM states, 3-bit encoding: IDLE=000, CHK_CMD=001, READ_ADD=010, READ_DATA=011, WRITE=100; no other encodings reachable.
REQ-013 IDLE transitions to CHK_CMD when SS_n=0; otherwise stays in IDLE.
REQ-014 CHK_CMD consumes no bit: MOSI=0 -> WRITE; MOSI=1 and addr_rcvd=0 -> READ_ADD; MOSI=1 and addr_rcvd=1 -> READ_DATA.
REQ-015 WRITE, READ_ADD and READ_DATA shift in MOSI, MSB first, starting with the bit present on entry; the bit counter counts 0..FRAME_W-1.
REQ-016 The cycle after the FRAME_W-th bit: rx_data = shift register contents and rx_valid=1 for exactly one cycle; rx_data holds until the next frame completes.
REQ-017 rx_valid completing in READ_ADD sets addr_rcvd=1; rx_valid completing in READ_DATA clears addr_rcvd after the output byte.
REQ-018 WRITE and READ_ADD, after rx_valid, remain in state with no further shifting until SS_n=1.
REQ-019 READ_DATA, after rx_valid: wait for tx_valid (no timeout); capture tx_data; drive MISO with bits [ADDR_SIZE-1:0], MSB first, one bit per clk, starting the cycle after capture.
REQ-020 MISO SHALL be 0 whenever no output bit is being driven.
REQ-021 tx_valid outside the READ_DATA wait window SHALL be ignored.
REQ-022 SS_n=1 in any state -> IDLE next cycle: bit counter cleared, partial frame discarded (no rx_valid), MISO=0, addr_rcvd retained.
REQ-023 SS_n rising on the same cycle the last frame bit is sampled: the bit is discarded and no rx_valid is issued.

Reset
REQ-024 rst_n=0 SHALL immediately force: state=IDLE, counter=0, shift register=0, rx_data=0, rx_valid=0, MISO=0, addr_rcvd=0, captured tx byte=0.
REQ-025 Reset mid-frame SHALL discard the frame; operation resumes at the first rising clk edge after rst_n deassertion.

Configuration
REQ-026 Macro SPI_BURST_EN, when defined: after the last MISO bit of a byte, if SS_n is still 0, rx_valid re-pulses with rx_data={2'b11, last payload} and REQ-019 repeats (RAM auto-increments); addr_rcvd clears only at SS_n=1.
REQ-027 Without SPI_BURST_EN: after one byte, MISO=0, FSM holds in READ_DATA until SS_n=1; addr_rcvd clears after the byte.

Verification (ADDR_SIZE=8)
REQ-028 SS_n=0, MOSI 00_1010_0101 -> state WRITE; rx_data=10'h0A5 with one-cycle rx_valid 11 cycles after SS_n fall.
REQ-029 Frame 10_0011_0000, then a new frame 11_0000_0000, tx_data=8'hC3 with tx_valid -> addr_rcvd=1 after the first frame; MISO 1,1,0,0,0,0,1,1 after the second; addr_rcvd=0 afterwards.
REQ-030 MOSI 11_xxxx with addr_rcvd=0 -> FSM enters READ_ADD, not READ_DATA.
REQ-031 SS_n raised after 5 bits -> no rx_valid; IDLE next cycle; the next full frame is received correctly.
REQ-032 rst_n pulsed low mid READ_DATA shift-out -> MISO=0, rx_valid=0 and addr_rcvd=0 immediately, without a clk edge.
REQ-033 SPI_BURST_EN defined, SS_n held low, tx_data 8'hC3 then 8'h3C -> two rx_valid=10'h300 pulses; MISO streams C3 then 3C. Without the macro -> MISO stays 0 after C3.
